// File: rtl/icache_fetch_arbiter_if.sv
// Fetch-port bundle between NumReq requesters, the arbiter and the downstream
// instruction-cache port.
`default_nettype none

interface icache_fetch_arbiter_if #(
  parameter int NumReq    = 2,
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32
);
  logic [NumReq-1:0]                in_req_i;
  logic [NumReq-1:0][AddrWidth-1:0] in_addr_i;
  logic [NumReq-1:0]                in_gnt_o;
  logic [NumReq-1:0]                in_rvalid_o;
  logic [NumReq-1:0][DataWidth-1:0] in_rdata_o;
  logic [NumReq-1:0]                in_rerror_o;
  logic                             out_req_o;
  logic [AddrWidth-1:0]             out_addr_o;
  logic                             out_gnt_i;
  logic                             out_rvalid_i;
  logic [DataWidth-1:0]             out_rdata_i;
  logic                             out_rerror_i;

  modport slave (
    input  in_req_i, in_addr_i, out_gnt_i, out_rvalid_i, out_rdata_i, out_rerror_i,
    output in_gnt_o, in_rvalid_o, in_rdata_o, in_rerror_o, out_req_o, out_addr_o
  );

  modport master (
    output in_req_i, in_addr_i, out_gnt_i, out_rvalid_i, out_rdata_i, out_rerror_i,
    input  in_gnt_o, in_rvalid_o, in_rdata_o, in_rerror_o, out_req_o, out_addr_o
  );
endinterface

`default_nettype wire

// File: rtl/icache_fetch_arbiter.sv
// Round-robin arbiter with locked grant sharing one I-cache fetch port; an ID
// FIFO routes in-order responses back to the requester that issued each fetch.
`default_nettype none

module icache_fetch_arbiter #(
  parameter int NumReq         = 2,
  parameter int AddrWidth      = 32,
  parameter int DataWidth      = 32,
  parameter int MaxOutstanding = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  icache_fetch_arbiter_if.slave  bus,
  output logic                   busy_o
);

  localparam int IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int CntW = $clog2(MaxOutstanding + 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumReq - 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(MaxOutstanding - 1);
  localparam logic [CntW-1:0] MaxCnt  = CntW'(MaxOutstanding);

  logic [IdxW-1:0] rr_q;
  logic [IdxW-1:0] lock_q;
  logic            locked_q;
  logic [IdxW-1:0] fifo_q [MaxOutstanding];
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [CntW-1:0] count_q;

  logic [IdxW-1:0] winner;
  logic [IdxW-1:0] sel;
  logic [IdxW-1:0] head;
  logic [IdxW-1:0] cand_idx;
  int              cand;
  logic            found;
  logic            fifo_empty;
  logic            fifo_full;
  logic            push;
  logic            pop;
  logic            handshake;

  always_comb begin
    winner   = rr_q;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int i = 0; i < NumReq; i++) begin
      cand     = (int'(rr_q) + i) % NumReq;
      cand_idx = IdxW'(cand);
      if (!found && bus.in_req_i[cand_idx]) begin
        winner = cand_idx;
        found  = 1'b1;
      end
    end
  end

  assign fifo_empty = (count_q == '0);
  assign head       = fifo_q[rd_ptr_q];
  assign pop        = bus.out_rvalid_i & ~fifo_empty;
  // A same-cycle pop frees a slot, so a full FIFO still accepts a new grant.
  assign fifo_full  = (count_q == MaxCnt) & ~pop;
  assign sel        = locked_q ? lock_q : winner;

  assign bus.out_req_o  = (|bus.in_req_i) & ~fifo_full;
  assign bus.out_addr_o = bus.out_req_o ? bus.in_addr_i[sel] : '0;
  assign handshake      = bus.out_req_o & bus.out_gnt_i;
  assign push           = handshake;
  assign busy_o         = ~fifo_empty;
  assign bus.in_rdata_o = {NumReq{bus.out_rdata_i}};

  always_comb begin
    bus.in_gnt_o    = '0;
    bus.in_rvalid_o = '0;
    bus.in_rerror_o = '0;
    if (handshake) begin
      bus.in_gnt_o[sel] = 1'b1;
    end
    if (pop) begin
      bus.in_rvalid_o[head] = 1'b1;
      bus.in_rerror_o[head] = bus.out_rerror_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q     <= '0;
      lock_q   <= '0;
      locked_q <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < MaxOutstanding; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      if (handshake) begin
        rr_q     <= (sel == LastIdx) ? '0 : sel + 1'b1;
        locked_q <= 1'b0;
      end else if (bus.out_req_o) begin
        locked_q <= 1'b1;
        lock_q   <= sel;
      end

      if (push) begin
        fifo_q[wr_ptr_q] <= sel;
        wr_ptr_q         <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
      end

      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Protocol checks on the requester and downstream sides.
  a_lock_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
    locked_q |-> bus.in_req_i[lock_q]);

  a_no_stray_rvalid: assert property (@(posedge clk_i) disable iff (!rst_ni)
    bus.out_rvalid_i |-> !fifo_empty);

endmodule

`default_nettype wire

// File: tb/tb_icache_fetch_arbiter.sv
// Scoreboard bench for icache_fetch_arbiter: 4 requesters, 2 outstanding.
`default_nettype none

module tb_icache_fetch_arbiter;

  localparam int NR = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MO = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  int   checks = 0;
  int   errors = 0;
  int   exp_q[$];

  always #5 clk = ~clk;

  icache_fetch_arbiter_if #(.NumReq(NR), .AddrWidth(AW), .DataWidth(DW)) bus ();

  icache_fetch_arbiter #(
    .NumReq(NR), .AddrWidth(AW), .DataWidth(DW), .MaxOutstanding(MO)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus.slave),
    .busy_o (busy)
  );

  task automatic idle();
    bus.in_req_i     = '0;
    bus.out_gnt_i    = 1'b0;
    bus.out_rvalid_i = 1'b0;
    bus.out_rdata_i  = '0;
    bus.out_rerror_i = 1'b0;
    for (int i = 0; i < NR; i++) bus.in_addr_i[i] = 32'h1000 + 32'(i * 16);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    exp_q.delete();
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (bus.in_gnt_o !== 4'b0) begin errors++; $display("FAIL reset_gnt got %b exp 0000", bus.in_gnt_o); end
    checks++; if (bus.in_rvalid_o !== 4'b0) begin errors++; $display("FAIL reset_rvalid got %b exp 0000", bus.in_rvalid_o); end
    checks++; if (bus.in_rerror_o !== 4'b0) begin errors++; $display("FAIL reset_rerror got %b exp 0000", bus.in_rerror_o); end
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    logic [NR-1:0] req [3] = '{4'b0010, 4'b0000, 4'b0000};
    logic          gnt [3] = '{1'b1, 1'b0, 1'b0};
    logic          rv  [3] = '{1'b0, 1'b1, 1'b0};
    logic [NR-1:0] eg  [3] = '{4'b0010, 4'b0000, 4'b0000};
    logic          eb  [3] = '{1'b0, 1'b1, 1'b0};
    logic [NR-1:0] ev;
    do_reset();
    bus.in_addr_i[1] = 32'h100;
    for (int c = 0; c < 3; c++) begin
      bus.in_req_i = req[c]; bus.out_gnt_i = gnt[c]; bus.out_rvalid_i = rv[c];
      bus.out_rdata_i = 32'hDEAD;
      ev = '0;
      if (rv[c] && exp_q.size() > 0) ev[exp_q.pop_front()] = 1'b1;
      @(negedge clk);
      checks++; if (bus.in_gnt_o !== eg[c]) begin errors++; $display("FAIL single_gnt c=%0d got %b exp %b", c, bus.in_gnt_o, eg[c]); end
      checks++; if (bus.in_rvalid_o !== ev) begin errors++; $display("FAIL single_rvalid c=%0d got %b exp %b", c, bus.in_rvalid_o, ev); end
      checks++; if (busy !== eb[c]) begin errors++; $display("FAIL single_busy c=%0d got %b exp %b", c, busy, eb[c]); end
      if (c == 0) begin
        checks++; if (bus.out_addr_o !== 32'h100) begin errors++; $display("FAIL single_addr got %h exp 00000100", bus.out_addr_o); end
      end
      if (c == 1) begin
        checks++; if (bus.in_rdata_o[1] !== 32'hDEAD) begin errors++; $display("FAIL single_rdata got %h exp 0000dead", bus.in_rdata_o[1]); end
      end
      for (int b = 0; b < NR; b++) if (eg[c][b]) exp_q.push_back(b);
      next_cycle();
    end
    idle();
  endtask

  task automatic test_round_robin();
    logic [NR-1:0] eg, ev;
    int            id;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      bus.in_req_i     = (k < 5) ? 4'b1111 : 4'b0000;
      bus.out_gnt_i    = 1'b1;
      bus.out_rvalid_i = (k > 0);
      bus.out_rdata_i  = 32'hA000 + 32'(k);
      eg = (k < 5) ? (4'b0001 << (k % NR)) : 4'b0000;
      ev = '0;
      id = -1;
      if (k > 0 && exp_q.size() > 0) begin
        id = exp_q.pop_front();
        ev[id] = 1'b1;
      end
      @(negedge clk);
      checks++; if (bus.in_gnt_o !== eg) begin errors++; $display("FAIL rr_gnt k=%0d got %b exp %b", k, bus.in_gnt_o, eg); end
      checks++; if (bus.in_rvalid_o !== ev) begin errors++; $display("FAIL rr_rvalid k=%0d got %b exp %b", k, bus.in_rvalid_o, ev); end
      if (k < 5) begin
        checks++;
        if (bus.out_addr_o !== 32'h1000 + 32'((k % NR) * 16)) begin
          errors++; $display("FAIL rr_addr k=%0d got %h exp %h", k, bus.out_addr_o, 32'h1000 + 32'((k % NR) * 16));
        end
      end
      if (id >= 0) begin
        checks++;
        if (bus.in_rdata_o[id] !== 32'hA000 + 32'(k)) begin
          errors++; $display("FAIL rr_rdata k=%0d got %h exp %h", k, bus.in_rdata_o[id], 32'hA000 + 32'(k));
        end
      end
      if (k < 5) exp_q.push_back(k % NR);
      next_cycle();
    end
    idle();
  endtask

  task automatic test_lock();
    logic [NR-1:0] req [6] = '{4'b0100, 4'b0101, 4'b0101, 4'b0101, 4'b0001, 4'b0000};
    logic          gnt [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic          rv  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [NR-1:0] eg  [6] = '{4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0001, 4'b0000};
    logic [AW-1:0] ea  [6] = '{32'h1020, 32'h1020, 32'h1020, 32'h1020, 32'h1000, 32'h0};
    logic [NR-1:0] ev;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      bus.in_req_i = req[c]; bus.out_gnt_i = gnt[c]; bus.out_rvalid_i = rv[c];
      ev = '0;
      if (rv[c] && exp_q.size() > 0) ev[exp_q.pop_front()] = 1'b1;
      @(negedge clk);
      checks++; if (bus.in_gnt_o !== eg[c]) begin errors++; $display("FAIL lock_gnt c=%0d got %b exp %b", c, bus.in_gnt_o, eg[c]); end
      checks++; if (bus.out_addr_o !== ea[c]) begin errors++; $display("FAIL lock_addr c=%0d got %h exp %h", c, bus.out_addr_o, ea[c]); end
      checks++; if (bus.in_rvalid_o !== ev) begin errors++; $display("FAIL lock_rvalid c=%0d got %b exp %b", c, bus.in_rvalid_o, ev); end
      for (int b = 0; b < NR; b++) if (eg[c][b]) exp_q.push_back(b);
      next_cycle();
    end
    idle();
  endtask

  task automatic test_outstanding();
    logic [NR-1:0] req [9] = '{4'b0111, 4'b0110, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
    logic          rv  [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [NR-1:0] eg  [9] = '{4'b0001, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
    logic          eo  [9] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic          eb  [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [NR-1:0] ev;
    do_reset();
    for (int c = 0; c < 9; c++) begin
      bus.in_req_i = req[c]; bus.out_gnt_i = 1'b1; bus.out_rvalid_i = rv[c];
      ev = '0;
      if (rv[c] && exp_q.size() > 0) ev[exp_q.pop_front()] = 1'b1;
      @(negedge clk);
      checks++; if (bus.in_gnt_o !== eg[c]) begin errors++; $display("FAIL lim_gnt c=%0d got %b exp %b", c, bus.in_gnt_o, eg[c]); end
      checks++; if (bus.out_req_o !== eo[c]) begin errors++; $display("FAIL lim_req c=%0d got %b exp %b", c, bus.out_req_o, eo[c]); end
      checks++; if (busy !== eb[c]) begin errors++; $display("FAIL lim_busy c=%0d got %b exp %b", c, busy, eb[c]); end
      checks++; if (bus.in_rvalid_o !== ev) begin errors++; $display("FAIL lim_rvalid c=%0d got %b exp %b", c, bus.in_rvalid_o, ev); end
      for (int b = 0; b < NR; b++) if (eg[c][b]) exp_q.push_back(b);
      next_cycle();
    end
    idle();
  endtask

  task automatic test_error();
    logic [NR-1:0] req [4] = '{4'b1000, 4'b0001, 4'b0000, 4'b0000};
    logic          rv  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic          er  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [NR-1:0] eg  [4] = '{4'b1000, 4'b0001, 4'b0000, 4'b0000};
    logic [NR-1:0] ee  [4] = '{4'b0000, 4'b1000, 4'b0000, 4'b0000};
    logic [NR-1:0] ev;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      bus.in_req_i = req[c]; bus.out_gnt_i = 1'b1; bus.out_rvalid_i = rv[c]; bus.out_rerror_i = er[c];
      ev = '0;
      if (rv[c] && exp_q.size() > 0) ev[exp_q.pop_front()] = 1'b1;
      @(negedge clk);
      checks++; if (bus.in_gnt_o !== eg[c]) begin errors++; $display("FAIL err_gnt c=%0d got %b exp %b", c, bus.in_gnt_o, eg[c]); end
      checks++; if (bus.in_rvalid_o !== ev) begin errors++; $display("FAIL err_rvalid c=%0d got %b exp %b", c, bus.in_rvalid_o, ev); end
      checks++; if (bus.in_rerror_o !== ee[c]) begin errors++; $display("FAIL err_rerror c=%0d got %b exp %b", c, bus.in_rerror_o, ee[c]); end
      for (int b = 0; b < NR; b++) if (eg[c][b]) exp_q.push_back(b);
      next_cycle();
    end
    idle();
  endtask

  task automatic test_reset_midflight();
    do_reset();
    bus.out_gnt_i = 1'b1;
    bus.in_req_i  = 4'b0011;
    next_cycle();
    bus.in_req_i  = 4'b0010;
    next_cycle();
    bus.in_req_i  = 4'b0000;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before got %b exp 1", busy); end
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy_async got %b exp 0", busy); end
    bus.out_rvalid_i = 1'b1;
    #1;
    checks++; if (bus.in_rvalid_o !== 4'b0) begin errors++; $display("FAIL mid_stray_rvalid got %b exp 0000", bus.in_rvalid_o); end
    bus.out_rvalid_i = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    bus.in_req_i = 4'b1111;
    @(negedge clk);
    checks++; if (bus.in_gnt_o !== 4'b0001) begin errors++; $display("FAIL mid_rr_restart got %b exp 0001", bus.in_gnt_o); end
    exp_q.push_back(0);
    next_cycle();
    bus.in_req_i = 4'b0000;
    bus.out_rvalid_i = 1'b1;
    @(negedge clk);
    checks++; if (bus.in_rvalid_o !== 4'b0001) begin errors++; $display("FAIL mid_resp got %b exp 0001", bus.in_rvalid_o); end
    void'(exp_q.pop_front());
    next_cycle();
    idle();
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy_end got %b exp 0", busy); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_lock();
    test_outstanding();
    test_error();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/icache_fetch_arbiter.md
# icache_fetch_arbiter

Shares one instruction-cache fetch port between `NumReq` requesters (cores or prefetchers) using round-robin arbitration with a locked grant. The block sits between the cores and one fetch port of the cluster instruction-cache wrapper. It tracks outstanding fetches in an ID FIFO so that in-order responses return to the requester that issued them. Downstream, it presents a single req/gnt/rvalid fetch interface with the same semantics as the cache wrapper's port.

## Interface
- `NumReq`, 2: number of upstream requesters; >= 2.
- `AddrWidth`, 32: fetch address width.
- `DataWidth`, 32: fetch data width.
- `MaxOutstanding`, 2: maximum number of granted fetches that have not yet returned; >= 1.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `in_req_i`  in  NumReq  per-requester fetch request.
- `in_addr_i`  in  NumReq x AddrWidth  per-requester fetch address.
- `in_gnt_o`  out  NumReq  per-requester grant; one-hot or zero.
- `in_rvalid_o`  out  NumReq  per-requester response valid; one-hot or zero.
- `in_rdata_o`  out  NumReq x DataWidth  response data, broadcast to all requesters.
- `in_rerror_o`  out  NumReq  response error, qualified by `in_rvalid_o`.
- `out_req_o`  out  1  downstream fetch request.
- `out_addr_o`  out  AddrWidth  downstream address.
- `out_gnt_i`  in  1  downstream grant.
- `out_rvalid_i`  in  1  downstream response valid; responses arrive in grant order.
- `out_rdata_i`  in  DataWidth  downstream response data.
- `out_rerror_i`  in  1  downstream response error.
- `busy_o`  out  1  high while at least one fetch is outstanding.

## Operation
- **Arbitration**
  - Round-robin pointer `rr_q` (log2 NumReq bits), reset 0.
  - The winner is the first requester with `in_req_i` high, searching from `rr_q` upward with wrap-around.
  - On a downstream handshake (`out_req_o & out_gnt_i`), `rr_q` becomes winner+1, modulo NumReq.
- **Lock**
  - If `out_req_o` is high and `out_gnt_i` is low, latch the winner index in `lock_q` and set `locked_q`.
  - While `locked_q` is set, the selection is forced to `lock_q`. `out_req_o` and `out_addr_o` must not change until the grant.
  - `locked_q` clears on the handshake.
  - Requesters must keep `req` and `addr` stable until granted. A locked requester that drops `req` is a protocol violation; flag it with an assertion.
- **Outstanding limit**
  - `out_req_o = |in_req_i & !fifo_full`.
  - When the FIFO is full, no requester is selected and no grant is issued.
- **Grant**
  - `in_gnt_o[w] = out_gnt_i & out_req_o` for winner `w` only.
  - `out_addr_o = in_addr_i[w]`.
  - When `out_req_o` is low, `out_addr_o` is driven to 0.
- **ID FIFO**
  - Depth MaxOutstanding, entries of log2 NumReq bits.
  - Push winner index on a handshake; pop on `out_rvalid_i`.
  - A push and a pop may occur in the same cycle, including when the FIFO is full; the count stays unchanged.
  - Occupancy counter is 0..MaxOutstanding; read and write pointers wrap modulo MaxOutstanding.
- **Response routing**
  - `in_rvalid_o[fifo_head] = out_rvalid_i`.
  - `in_rerror_o[fifo_head] = out_rerror_i`.
  - `in_rdata_o[*] = out_rdata_i`.
  - `out_rvalid_i` while the FIFO is empty is a protocol violation. It is dropped (no `in_rvalid_o`, no pop) and flagged by an assertion.
- `busy_o = (count != 0)`.

## Timing
- Request path is combinational: `in_req_i` to `out_req_o` and `in_gnt_o` in the same cycle, with no added request latency.
- Response path is combinational: `out_rvalid_i` to `in_rvalid_o` in the same cycle.
- Downstream `out_rvalid_i` for a fetch arrives no earlier than the cycle after its grant. A response in the same cycle as a push is therefore always for an older entry.
- Full throughput: one grant per cycle while `count < MaxOutstanding`, or when a pop occurs in the same cycle.
- Reset values: `rr_q=0`, `locked_q=0`, `count=0`, `busy_o=0`; all `in_gnt_o`, `in_rvalid_o`, `in_rerror_o` are 0.
  - `out_req_o` follows `in_req_i` combinationally from reset release.
- Reset asserted mid-operation clears the FIFO and lock immediately. Responses for fetches granted before reset are dropped as protocol violations; the integrator must reset the downstream cache together with this block.

## Test plan
- **Single requester:** `in_req_i=4'b0010`, addr `0x100`, `out_gnt_i=1`, rvalid one cycle later with data `0xDEAD` -> `in_gnt_o=4'b0010` in cycle 0; `in_rvalid_o=4'b0010` and `in_rdata_o=0xDEAD` in cycle 1; `busy_o` high only in cycle 1.
- **Round-robin fairness:** all 4 requesting continuously, `out_gnt_i=1`, immediate responses -> grants in order 0,1,2,3,0; each response routed to the matching requester.
- **Lock under stall:** requester 2 wins while `out_gnt_i=0` for 3 cycles, and requester 0 raises `req` during the stall -> `out_addr_o` stays requester 2's address; the grant goes to 2 when `out_gnt_i` rises, then to 3 or 0 on the next handshake.
- **Outstanding limit:** MaxOutstanding=2, two grants with no responses -> `out_req_o=0` in the third cycle. A response and a new grant in the same cycle keep `count` at 2 and route the response to the first granted requester.
- **Error routing:** requester 3 response with `out_rerror_i=1` -> `in_rerror_o=4'b1000`; no other bit set.
- **Reset mid-flight:** two fetches outstanding, pulse `rst_ni` low asynchronously -> `busy_o=0`, `count=0`, and `rr_q=0` immediately; a later stray `out_rvalid_i` produces no `in_rvalid_o`.
